// File: rtl/arm_fetch_pkg.sv
// Shared fetch-path types and constants: queue entry layout and PC arithmetic.
package arm_fetch_pkg;

    localparam int FQ_DEPTH = 4;
    localparam int INSTR_W  = 32;

    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] PC_PLUS8_OFS = 32'd8;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fq_entry_t;

    // Decode sees the pipeline-visible PC (fetch PC + 8).
    function automatic logic [31:0] pc_plus8(input logic [31:0] pc);
        return pc + PC_PLUS8_OFS;
    endfunction

endpackage

// File: rtl/fq_storage.sv
// Circular entry buffer for the fetch queue: one write port at the tail, one
// asynchronous read port at the head. Pointer and count control live in the parent.
module fq_storage
    import arm_fetch_pkg::*;
#(
    parameter  int DEPTH = FQ_DEPTH,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [PW-1:0]      i_wptr,
    input  logic [INSTR_W-1:0] i_winstr,
    input  logic [31:0]        i_wpc,
    input  logic [PW-1:0]      i_rptr,
    output logic [INSTR_W-1:0] o_rinstr,
    output logic [31:0]        o_rpc
);

    fq_entry_t r_mem [DEPTH];

    // NOTE: the array has no reset; the parent's count qualifies every read,
    // so stale contents are never observed and the RAM stays reset-free.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wptr] <= '{instr: i_winstr, pc: i_wpc};
        end
    end

    assign o_rinstr = r_mem[i_rptr].instr;
    assign o_rpc    = r_mem[i_rptr].pc;

endmodule

// File: rtl/fetch_queue.sv
// Prefetch queue between instruction memory and decode: owns the fetch PC,
// issues in-order word fetches, buffers responses and handles branch redirects.
module fetch_queue
    import arm_fetch_pkg::*;
#(
    parameter int          DEPTH    = FQ_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               ImemReq,
    output logic [31:0]        ImemAddr,
    input  logic               ImemGnt,
    input  logic               ImemRValid,
    input  logic [INSTR_W-1:0] ImemRData,
    input  logic               BranchTakenE,
    input  logic [31:0]        BranchTargetE,
    input  logic               StallD,
    output logic               ValidD,
    output logic [INSTR_W-1:0] InstrD,
    output logic [31:0]        PCPlus8D
);

    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   r_fpc;
    logic [31:0]   r_rpc;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_stale;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;

    logic               w_req;
    logic               w_issue;
    logic               w_stale_rsp;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;
    logic [CW:0]        w_occ;
    logic [CW-1:0]      w_outst_nxt;
    logic [INSTR_W-1:0] w_head_instr;
    logic [31:0]        w_head_pc;

    // Buffered entries plus in-flight fetches must never exceed the queue,
    // so every response that comes back has a slot reserved for it.
    assign w_occ   = {1'b0, r_cnt} + {1'b0, r_outst};
    assign w_req   = (w_occ < DEPTH_C) && !BranchTakenE;
    assign w_issue = w_req && ImemGnt;

    assign w_valid     = (r_cnt != '0);
    assign w_stale_rsp = ImemRValid && (r_stale != '0);
    assign w_push      = ImemRValid && !w_stale_rsp && !BranchTakenE;
    assign w_pop       = w_valid && !StallD;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        w_outst_nxt = r_outst;
        if (w_issue) begin
            w_outst_nxt = w_outst_nxt + CW'(1);
        end
        if (ImemRValid) begin
            w_outst_nxt = w_outst_nxt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fpc   <= RESET_PC;
            r_rpc   <= RESET_PC;
            r_cnt   <= '0;
            r_outst <= '0;
            r_stale <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            if (BranchTakenE) begin
                // Everything still in flight belongs to the wrong path.
                r_fpc   <= BranchTargetE;
                r_rpc   <= BranchTargetE;
                r_cnt   <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_stale <= w_outst_nxt;
            end else begin
                if (w_issue) begin
                    r_fpc <= r_fpc + PC_STEP;
                end
                if (w_push) begin
                    r_tail <= r_tail + PW'(1);
                    r_rpc  <= r_rpc + PC_STEP;
                end
                if (w_pop) begin
                    r_head <= r_head + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + CW'(1);
                    2'b01:   r_cnt <= r_cnt - CW'(1);
                    default: r_cnt <= r_cnt;
                endcase
                if (w_stale_rsp) begin
                    r_stale <= r_stale - CW'(1);
                end
            end
        end
    end

    fq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk      (clk),
        .i_we     (w_push),
        .i_wptr   (r_tail),
        .i_winstr (ImemRData),
        .i_wpc    (r_rpc),
        .i_rptr   (r_head),
        .o_rinstr (w_head_instr),
        .o_rpc    (w_head_pc)
    );

    assign ImemReq  = w_req;
    assign ImemAddr = r_fpc;
    assign ValidD   = w_valid;
    assign InstrD   = w_valid ? w_head_instr : '0;
    assign PCPlus8D = w_valid ? pc_plus8(w_head_pc) : 32'h0;

    a_rsp_has_req: assert property (@(posedge clk) disable iff (!reset)
        ImemRValid |-> (r_outst != '0));

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
        w_push |-> (r_cnt != FULL_CNT));

    a_stale_bounded: assert property (@(posedge clk) disable iff (!reset)
        r_stale <= r_outst);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model with variable latency and a
// stream-level reference (expected fetch address, expected decode PC).
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XOR_PAT  = 32'hE000_0000;

    logic        clk;
    logic        reset;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRValid;
    logic [31:0] ImemRData;
    logic        BranchTakenE;
    logic [31:0] BranchTargetE;
    logic        StallD;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCPlus8D;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ImemReq       (ImemReq),
        .ImemAddr      (ImemAddr),
        .ImemGnt       (ImemGnt),
        .ImemRValid    (ImemRValid),
        .ImemRData     (ImemRData),
        .BranchTakenE  (BranchTakenE),
        .BranchTargetE (BranchTargetE),
        .StallD        (StallD),
        .ValidD        (ValidD),
        .InstrD        (InstrD),
        .PCPlus8D      (PCPlus8D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t       mem_q[$];
    int          n_pass, n_fail, n_total;
    int          cyc, lat_min, lat_max, epoch;
    int          issued_since, consumed_since;
    logic [31:0] exp_addr, exp_pc;
    logic        resp_this;
    int          pres_epoch;
    logic        last_req, last_rvalid, last_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mem_q.delete();
        epoch++;
        issued_since   = 0;
        consumed_since = 0;
        exp_addr       = RESET_PC;
        exp_pc         = RESET_PC;
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, update the model.
    task automatic step(input logic gnt, input logic stall, input logic br, input logic [31:0] tgt);
        int   new_if, outst, mcnt;
        logic exp_req, exp_valid;
        ImemGnt       = gnt;
        StallD        = stall;
        BranchTakenE  = br;
        BranchTargetE = tgt;
        resp_this     = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            ImemRValid = 1'b1;
            ImemRData  = mem_q[0].addr ^ XOR_PAT;
            pres_epoch = mem_q[0].epoch;
            resp_this  = 1'b1;
            void'(mem_q.pop_front());
        end else begin
            ImemRValid = 1'b0;
            ImemRData  = $urandom;
        end
        @(negedge clk);
        outst  = mem_q.size() + (resp_this ? 1 : 0);
        new_if = (resp_this && pres_epoch == epoch) ? 1 : 0;
        foreach (mem_q[i]) if (mem_q[i].epoch == epoch) new_if++;
        mcnt      = issued_since - consumed_since - new_if;
        exp_req   = !br && (mcnt + outst < DEPTH);
        exp_valid = (mcnt > 0);
        check("ImemReq", 32'(ImemReq), 32'(exp_req));
        check("ImemAddr", ImemAddr, exp_addr);
        check("ValidD", 32'(ValidD), 32'(exp_valid));
        check("InstrD", InstrD, exp_valid ? (exp_pc ^ XOR_PAT) : 32'h0);
        check("PCPlus8D", PCPlus8D, exp_valid ? (exp_pc + 32'd8) : 32'h0);
        last_req    = ImemReq;
        last_rvalid = ImemRValid;
        last_valid  = ValidD;
        if (exp_req && gnt) begin
            mem_q.push_back('{addr: exp_addr, due: cyc + $urandom_range(lat_max, lat_min), epoch: epoch});
            exp_addr = exp_addr + 32'd4;
            issued_since++;
        end
        if (exp_valid && !stall && !br) begin
            exp_pc = exp_pc + 32'd4;
            consumed_since++;
        end
        if (br) begin
            epoch++;
            issued_since   = 0;
            consumed_since = 0;
            exp_addr       = tgt;
            exp_pc         = tgt;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] head_instr, hold_addr, base_pc;
        int          c0, i0;
        logic        seen;

        n_pass = 0; n_fail = 0; n_total = 0;
        cyc = 0; epoch = 0; lat_min = 1; lat_max = 1;
        reset = 1'b0; ImemGnt = 1'b0; ImemRValid = 1'b0; ImemRData = '0;
        BranchTakenE = 1'b0; BranchTargetE = '0; StallD = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(ImemReq), 32'd1);
        check("rst_addr", ImemAddr, RESET_PC);
        check("rst_valid", 32'(ValidD), 32'd0);
        check("rst_instr", InstrD, 32'h0);
        check("rst_pc8", PCPlus8D, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // First fetch with 1-cycle memory: visible two cycles after issue
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("first_valid", 32'(ValidD), 32'd1);
        check("first_pc8", PCPlus8D, 32'h8);
        check("first_instr", InstrD, 32'h0 ^ XOR_PAT);

        // Sustained one instruction per cycle
        c0 = consumed_since;
        repeat (16) step(1'b1, 1'b0, 1'b0, 32'h0);
        check("throughput", 32'(consumed_since - c0), 32'd16);

        // Decode stall: fetching stops at the occupancy limit, head stable
        head_instr = exp_pc ^ XOR_PAT;
        i0 = issued_since;
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
        check("stall_issues_le_depth", 32'((issued_since - i0) <= DEPTH), 32'd1);
        check("stall_req_off", 32'(ImemReq), 32'd0);
        check("stall_head", InstrD, head_instr);
        base_pc = exp_pc;
        for (int k = 0; k < 4; k++) begin
            check("drain_order", PCPlus8D, base_pc + 32'd8 + 32'(4 * k));
            step(1'b1, 1'b0, 1'b0, 32'h0);
        end

        // Redirect with two fetches outstanding on a 3-cycle memory
        lat_min = 3; lat_max = 3;
        step(1'b0, 1'b0, 1'b1, 32'h200);
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("outst_two", 32'(mem_q.size()), 32'd2);
        step(1'b1, 1'b0, 1'b1, 32'h100);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (ValidD) seen = 1'b1;
            else step(1'b1, 1'b0, 1'b0, 32'h0);
        end
        check("br3_valid_seen", 32'(seen), 32'd1);
        check("br3_first_pc8", PCPlus8D, 32'h108);
        check("br3_first_instr", InstrD, 32'h100 ^ XOR_PAT);

        // Redirect coinciding with a response and a pop, 1-cycle memory
        lat_min = 1; lat_max = 1;
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h300);
        check("brc_rvalid", 32'(last_rvalid), 32'd1);
        check("brc_valid_before", 32'(last_valid), 32'd1);
        check("brc_req_off", 32'(last_req), 32'd0);
        check("brc_cleared", 32'(ValidD), 32'd0);
        BranchTakenE = 1'b0;
        #1;
        check("brc_req_target", 32'(ImemReq), 32'd1);
        check("brc_addr_target", ImemAddr, 32'h300);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("brc_valid_n3", 32'(ValidD), 32'd1);
        check("brc_pc8_n3", PCPlus8D, 32'h308);

        // Grant withheld: address holds
        hold_addr = exp_addr;
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("gnt_hold_addr", ImemAddr, hold_addr);
        step(1'b1, 1'b0, 1'b0, 32'h0);

        // PC wrap past 2^32
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic        g, s, b;
            logic [31:0] t;
            lat_min = 1; lat_max = 3;
            g = ($urandom_range(9, 0) < 7);
            s = ($urandom_range(9, 0) < 3);
            b = ($urandom_range(39, 0) == 0);
            t = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            step(g, s, b, t);
        end

        // Asynchronous reset mid-stream with a full queue
        lat_min = 1; lat_max = 1;
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
        check("full_req_off", 32'(ImemReq), 32'd0);
        check("full_valid", 32'(ValidD), 32'd1);
        #2;
        reset      = 1'b0;
        ImemRValid = 1'b0;
        #1;
        check("arst_valid", 32'(ValidD), 32'd0);
        check("arst_addr", ImemAddr, RESET_PC);
        check("arst_req", 32'(ImemReq), 32'd1);
        check("arst_instr", InstrD, 32'h0);
        check("arst_pc8", PCPlus8D, 32'h0);
        model_reset();
        @(negedge clk);
        reset   = 1'b1;
        ImemGnt = 1'b0;
        StallD  = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
